maze_pkt_gen: RTL

//  Parametrised packet-stimulus engine for MAZE node and mesh benches; one instance drives one node pkt_in port.

---
 rtl/maze_pkt_gen.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/maze_pkt_gen.sv
// Packet stimulus engine for one MAZE node input port: emits a configured run of
// packets with fixed, sweeping or LFSR-random targets over a valid/ready handshake.
module maze_pkt_gen #(
    parameter int          HP     = 0,
    parameter int          VP     = 0,
    parameter int          X_W    = 3,
    parameter int          Y_W    = 3,
    parameter int          TYPE_W = 2,
    parameter int          QOS_W  = 1,
    parameter int          DATA_W = 8,
    parameter int          CNT_W  = 16,
    parameter int          GAP_W  = 4,
    parameter logic [15:0] SEED   = 16'hACE1,
    localparam int         NODE_W = X_W + Y_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        cfg_mode,
    input  logic [NODE_W-1:0] cfg_tgt,
    input  logic [TYPE_W-1:0] cfg_type,
    input  logic [QOS_W-1:0]  cfg_qos,
    input  logic [CNT_W-1:0]  cfg_num,
    input  logic [GAP_W-1:0]  cfg_gap,
    input  logic              pg_en,
    input  logic [NODE_W-1:0] pg_node,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [TYPE_W-1:0] out_type,
    output logic [QOS_W-1:0]  out_qos,
    output logic [NODE_W-1:0] out_src,
    output logic [NODE_W-1:0] out_tgt,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sent_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] M_SWEEP  = 2'd1;
    localparam logic [1:0] M_RANDOM = 2'd2;

    localparam logic [NODE_W-1:0] SRC_ID = {X_W'(HP), Y_W'(VP)};

    logic [1:0]        state;
    logic [1:0]        mode_q;
    logic [NODE_W-1:0] tgt_q;
    logic [CNT_W-1:0]  num_q;
    logic [GAP_W-1:0]  gap_q;
    logic [GAP_W-1:0]  gap_cnt;
    logic [15:0]       lfsr;

    logic              accept;
    logic              last;
    logic [CNT_W-1:0]  cnt_inc;
    logic [15:0]       lfsr_nxt;
    logic [NODE_W-1:0] tgt_first;
    logic [NODE_W-1:0] tgt_next;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic logic excluded(input logic [NODE_W-1:0] id,
                                      input logic              pe,
                                      input logic [NODE_W-1:0] pn);
        return (id == SRC_ID) || (pe && (id == pn));
    endfunction

    // At most two IDs are excluded, so two increments always land on a legal target
    function automatic logic [NODE_W-1:0] skip_excl(input logic [NODE_W-1:0] c,
                                                    input logic              pe,
                                                    input logic [NODE_W-1:0] pn);
        logic [NODE_W-1:0] t;
        t = c;
        for (int i = 0; i < 2; i++) begin
            if (excluded(t, pe, pn)) t = t + NODE_W'(1);
        end
        return t;
    endfunction

    function automatic logic [NODE_W-1:0] pick_tgt(input logic [1:0]        mode,
                                                   input logic [NODE_W-1:0] fixed,
                                                   input logic              first,
                                                   input logic [NODE_W-1:0] prev,
                                                   input logic [15:0]       lf,
                                                   input logic              pe,
                                                   input logic [NODE_W-1:0] pn);
        logic [NODE_W-1:0] t;
        case (mode)
            M_SWEEP:  t = skip_excl(first ? '0 : prev + NODE_W'(1), pe, pn);
            M_RANDOM: t = skip_excl(lf[NODE_W-1:0], pe, pn);
            default:  t = fixed;
        endcase
        return t;
    endfunction

    always_comb begin
        accept    = out_vld & out_rdy;
        cnt_inc   = sent_cnt + CNT_W'(1);
        last      = (cnt_inc == num_q);
        lfsr_nxt  = lfsr_adv(lfsr);
        tgt_first = pick_tgt(cfg_mode, cfg_tgt, 1'b1, '0, SEED, pg_en, pg_node);
        tgt_next  = pick_tgt(mode_q, tgt_q, 1'b0, out_tgt, lfsr_nxt, pg_en, pg_node);
    end

    assign out_src = SRC_ID;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            mode_q   <= '0;
            tgt_q    <= '0;
            num_q    <= '0;
            gap_q    <= '0;
            gap_cnt  <= '0;
            lfsr     <= SEED;
            out_vld  <= 1'b0;
            out_type <= '0;
            out_qos  <= '0;
            out_tgt  <= '0;
            out_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sent_cnt <= '0;
        end else if (abort) begin
            // A handshake completing alongside abort still counts
            state   <= S_IDLE;
            out_vld <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            if (accept) sent_cnt <= cnt_inc;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q   <= cfg_mode;
                        tgt_q    <= cfg_tgt;
                        num_q    <= cfg_num;
                        gap_q    <= cfg_gap;
                        out_type <= cfg_type;
                        out_qos  <= cfg_qos;
                        sent_cnt <= '0;
                        lfsr     <= SEED;
                        busy     <= 1'b1;
                        if (cfg_num == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= S_SEND;
                            out_vld  <= 1'b1;
                            out_tgt  <= tgt_first;
                            out_data <= '0;
                        end
                    end
                end
                S_SEND: begin
                    if (accept) begin
                        sent_cnt <= cnt_inc;
                        lfsr     <= lfsr_nxt;
                        if (last) begin
                            state   <= S_DONE;
                            out_vld <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            out_tgt  <= tgt_next;
                            out_data <= cnt_inc[DATA_W-1:0];
                            if (gap_q != '0) begin
                                state   <= S_GAP;
                                out_vld <= 1'b0;
                                gap_cnt <= gap_q;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt <= GAP_W'(1)) begin
                        state   <= S_SEND;
                        out_vld <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
